// File: rtl/snake_pkg.sv
// Shared snake-game definitions: cell encoding, FSM state encoding and
// the power-up food value used by food_gen and its consumers.
package snake_pkg;

    // Cell encoding: [X_MSB:X_LSB] is the column, [Y_MSB:Y_LSB] the row.
    localparam int CELL_W = 6;
    localparam int X_MSB  = 5;
    localparam int X_LSB  = 3;
    localparam int Y_MSB  = 2;
    localparam int Y_LSB  = 0;

    // food_eater sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GEN    = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    // Food value that food_gen presents out of reset; it counts as placed.
    localparam logic [6:0] FOOD_INIT = 7'b1001110;

endpackage

// File: rtl/food_eater.sv
// Food consumer/requester: detects the head landing on the food cell,
// asks food_gen for a new cell, and re-requests while the new cell sits
// on the snake body (bounded by MAX_RETRY). Drives grow and score.
module food_eater
    import snake_pkg::*;
#(
    parameter int SCORE_W   = 8,
    parameter int MAX_RETRY = 7,
    parameter int RETRY_W   = 3   // 2**RETRY_W must exceed MAX_RETRY
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               tick,
    input  logic [CELL_W-1:0]  head,
    input  logic [6:0]         food,
    input  logic               q_occ,
    output logic               gen,
    output logic               q_req,
    output logic [CELL_W-1:0]  q_pos,
    output logic               grow,
    output logic [SCORE_W-1:0] score,
    output logic               food_ok,
    output logic               food_bad
);

    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

    state_t              state_r;
    state_t              state_s;
    logic [RETRY_W-1:0]  retry_r;
    logic [RETRY_W-1:0]  retry_s;
    logic [SCORE_W-1:0]  score_s;
    logic [CELL_W-1:0]   q_pos_s;
    logic                gen_s;
    logic                q_req_s;
    logic                grow_s;
    logic                food_ok_s;
    logic                food_bad_s;
    logic                hit_s;
    logic                unused_food_msb_s;

    // food[6] carries no position information and is deliberately ignored.
    assign unused_food_msb_s = food[6];

    // A hit needs a move tick, a settled food cell and the head on it.
    assign hit_s = tick && food_ok && (head == food[CELL_W-1:0]);

    // Next-state and next-output logic; pulses default low, levels hold.
    always_comb begin
        state_s    = state_r;
        retry_s    = retry_r;
        score_s    = score;
        q_pos_s    = q_pos;
        food_ok_s  = food_ok;
        gen_s      = 1'b0;
        q_req_s    = 1'b0;
        grow_s     = 1'b0;
        food_bad_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (hit_s) begin
                    grow_s    = 1'b1;
                    gen_s     = 1'b1;
                    food_ok_s = 1'b0;
                    retry_s   = '0;
                    if (score != SCORE_MAX) begin
                        score_s = score + {{(SCORE_W-1){1'b0}}, 1'b1};
                    end else begin
                        score_s = score;
                    end
                    state_s = GEN;
                end else begin
                    state_s = IDLE;
                end
            end
            GEN: begin
                // food_gen captures the request at this edge.
                state_s = SETTLE;
            end
            SETTLE: begin
                // New food is stable now; query the body for it.
                q_req_s = 1'b1;
                q_pos_s = food[CELL_W-1:0];
                state_s = CHECK;
            end
            CHECK: begin
                if (!q_occ) begin
                    food_ok_s = 1'b1;
                    state_s   = IDLE;
                end else if (retry_r < RETRY_LAST) begin
                    retry_s = retry_r + {{(RETRY_W-1){1'b0}}, 1'b1};
                    gen_s   = 1'b1;
                    state_s = GEN;
                end else begin
                    // Out of retries: accept the occupied cell and flag it.
                    food_ok_s  = 1'b1;
                    food_bad_s = 1'b1;
                    state_s    = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r  <= IDLE;
            retry_r  <= '0;
            score    <= '0;
            q_pos    <= '0;
            gen      <= 1'b0;
            q_req    <= 1'b0;
            grow     <= 1'b0;
            food_ok  <= 1'b1;
            food_bad <= 1'b0;
        end else begin
            state_r  <= state_s;
            retry_r  <= retry_s;
            score    <= score_s;
            q_pos    <= q_pos_s;
            gen      <= gen_s;
            q_req    <= q_req_s;
            grow     <= grow_s;
            food_ok  <= food_ok_s;
            food_bad <= food_bad_s;
        end
    end

endmodule

// File: tb/tb_food_eater.sv
// Scoreboard bench for food_eater: stimulus pushes expected output events
// (kind, data, cycle) into a queue; a negedge monitor pops and compares
// every event the DUT presents.
module tb_food_eater;

    localparam int K_GEN  = 0;
    localparam int K_GROW = 1;
    localparam int K_QREQ = 2;
    localparam int K_OK   = 3;
    localparam int K_BAD  = 4;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } ev_t;

    logic       CLK;
    logic       RST_N;
    logic       tick;
    logic [5:0] head;
    logic [6:0] food_r;
    logic       q_occ;
    logic       gen;
    logic       q_req;
    logic [5:0] q_pos;
    logic       grow;
    logic [7:0] score;
    logic       food_ok;
    logic       food_bad;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   chk_cnt = 0;
    int   occ_budget = 0;
    int   exp_score = 0;
    logic [5:0] exp_cell = 6'b001110;
    bit   mon_en = 1'b0;
    bit   ok_prev = 1'b1;
    logic gen_q;

    food_eater #(.SCORE_W(8), .MAX_RETRY(7), .RETRY_W(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .tick(tick), .head(head), .food(food_r),
        .q_occ(q_occ), .gen(gen), .q_req(q_req), .q_pos(q_pos), .grow(grow),
        .score(score), .food_ok(food_ok), .food_bad(food_bad)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cycle counter: value k is seen after the k-th rising edge.
    always @(posedge CLK) cyc <= cyc + 1;

    // food_gen model: new cell = old cell + 29 (mod 64), bit 6 toggles.
    always @(posedge CLK) begin
        if (!RST_N) begin
            food_r <= 7'b1001110;
            gen_q  <= 1'b0;
        end else begin
            gen_q <= gen;
            if (gen && !gen_q) food_r <= {~food_r[6], food_r[5:0] + 6'd29};
        end
        if (q_req) chk_cnt <= chk_cnt + 1;
    end

    // Body model: the next occ_budget-chk_cnt queries report occupied.
    assign q_occ = q_req && (chk_cnt < occ_budget);

    task automatic push(input int kind, input int data, input int c);
        ev_t e;
        e.kind = kind; e.data = data; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input int data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: actual kind=%0d data=%0d cycle=%0d, required none",
                     kind, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data != data || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: actual kind=%0d data=%0d cycle=%0d, required kind=%0d data=%0d cycle=%0d",
                         kind, data, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: every output event is matched against the scoreboard.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (gen)                 expect_ev(K_GEN, 0);
            if (grow)                expect_ev(K_GROW, int'(score));
            if (q_req)               expect_ev(K_QREQ, int'(q_pos));
            if (food_ok && !ok_prev) expect_ev(K_OK, 0);
            if (food_bad)            expect_ev(K_BAD, 0);
            ok_prev = food_ok;
        end
    end

    // One hit; occ = number of checks answered occupied. Optional ticks
    // on the food cell while it is unsettled must give no grow.
    task automatic hit(input int occ, input bit noisy);
        int t;
        int qc;
        int t_end;
        @(negedge CLK);
        head = food_r[5:0];
        tick = 1'b1;
        t = cyc + 1;
        occ_budget = chk_cnt + occ;
        exp_score = (exp_score == 255) ? 255 : exp_score + 1;
        push(K_GEN, 0, t);
        push(K_GROW, exp_score, t);
        exp_cell = exp_cell + 6'd29;
        t_end = t + 4;
        for (int k = 0; k <= 7; k++) begin
            qc = t + 2 + 3 * k;
            push(K_QREQ, int'(exp_cell), qc);
            if (k < occ && k < 7) begin
                push(K_GEN, 0, qc + 1);
                exp_cell = exp_cell + 6'd29;
            end else begin
                push(K_OK, 0, qc + 1);
                if (k < occ) push(K_BAD, 0, qc + 1);
                t_end = qc + 2;
                break;
            end
        end
        while (cyc < t_end) begin
            @(negedge CLK);
            tick = noisy && (cyc <= t_end - 2);
            head = food_r[5:0];
        end
        tick = 1'b0;
    endtask

    initial begin : stim
        int t;
        RST_N = 1'b0;
        tick  = 1'b0;
        head  = 6'd0;
        repeat (3) @(negedge CLK);
        check("reset_score", int'(score), 0);
        check("reset_food_ok", int'(food_ok), 1);
        check("reset_gen", int'(gen), 0);
        check("reset_grow", int'(grow), 0);
        check("reset_q_req", int'(q_req), 0);
        check("reset_q_pos", int'(q_pos), 0);
        check("reset_food_bad", int'(food_bad), 0);
        RST_N  = 1'b1;
        mon_en = 1'b1;

        // Miss: head away from the food cell.
        @(negedge CLK);
        head = 6'b000000;
        tick = 1'b1;
        @(negedge CLK);
        tick = 1'b0;
        repeat (5) @(negedge CLK);

        // Hit on power-up food; new food 0101011, free cell.
        hit(0, 1'b0);
        check("food_after_first_hit", int'(food_r), 7'b0101011);
        // Two occupied checks then free.
        hit(2, 1'b0);
        check("retry_after_two", int'(dut.retry_r), 2);
        // Always occupied, with ticks on the food cell throughout.
        hit(100, 1'b1);
        check("food_ok_after_bad", int'(food_ok), 1);

        // Saturation.
        for (int i = 0; i < 256; i++) hit(0, 1'b0);
        check("score_saturated", int'(score), 255);

        // Reset during SETTLE.
        @(negedge CLK);
        head = food_r[5:0];
        tick = 1'b1;
        t = cyc + 1;
        push(K_GEN, 0, t);
        push(K_GROW, 255, t);
        push(K_OK, 0, t + 2);
        @(negedge CLK);
        tick = 1'b0;
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        check("rst_state", int'(dut.state_r), 0);
        check("rst_gen", int'(gen), 0);
        check("rst_q_req", int'(q_req), 0);
        check("rst_score", int'(score), 0);
        check("rst_food_ok", int'(food_ok), 1);
        RST_N = 1'b1;
        exp_cell = 6'b001110;
        repeat (5) @(negedge CLK);
        check("pending_events", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
